// File: rtl/uart_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_io_ctrl
//  Purpose  : Responder for the exec-stage UART request interface. Serialises
//             written bytes onto txd (8N1, LSB first) and deserialises rxd
//             into a small receive FIFO that serves read requests.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_io_ctrl #(
  parameter int CLK_PER_BIT = 868,
  parameter int RX_AW       = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_wenable,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  output logic        uart_rdone,
  output logic [31:0] uart_rd,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_overflow,
  output logic        rx_frame_err
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << RX_AW;
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  // Only the low byte of the write word is ever transmitted.
  logic unused_wd_hi;
  assign unused_wd_hi = ^uart_wd[31:8];

  // ---------------- state ----------------
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;

  logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [RX_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rdone_q, rdone_d;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic          wdone_q, wdone_d;
  logic          wdone_defer_q, wdone_defer_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  // ---------------- combinational helpers ----------------
  logic       tx_free, tx_load;
  logic [7:0] tx_load_byte;
  logic       rx_s, rx_push;
  logic       fifo_empty, fifo_full;
  logic       want_rd, pop_mem, bypass, wr_en, wreq;

  assign rx_s = rx_sync2_q;

  // TX framing FSM plus the one-entry pending write register
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    txd_d        = txd_q;
    pend_valid_d = pend_valid_q;
    pend_byte_d  = pend_byte_q;
    // The FSM can take a new byte when idle or on the last stop-bit cycle,
    // which is what makes consecutive frames gapless.
    tx_free      = (tx_state_q == TX_IDLE) ||
                   ((tx_state_q == TX_STOP) && (tx_cnt_q == C_BIT_LAST));
    tx_load      = tx_free && (pend_valid_q || uart_wenable);
    tx_load_byte = pend_valid_q ? pend_byte_q : uart_wd[7:0];

    case (tx_state_q)
      TX_START: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (tx_load) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_shift_d = tx_load_byte;
      txd_d      = 1'b0;
    end

    // A write arriving while the pending slot is occupied is ignored.
    if (tx_free) begin
      pend_valid_d = 1'b0;
    end else if (uart_wenable && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_byte_d  = uart_wd[7:0];
    end
  end

  // RX framing FSM on the synchronised line
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = frame_err_q;
    rx_push     = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == C_HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          // Line already back high at mid start bit: treat as noise.
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_WAIT: begin
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive FIFO, read request service and done-pulse arbitration
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_byte_d     = rd_byte_q;
    overflow_d    = overflow_q;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[RX_AW] != rd_ptr_q[RX_AW]) &&
                 (wr_ptr_q[RX_AW-1:0] == rd_ptr_q[RX_AW-1:0]);

    want_rd = uart_renable || rd_pend_q;
    pop_mem = want_rd && !fifo_empty;
    // Empty FIFO with a waiting reader: the fresh byte goes straight out.
    bypass  = want_rd && fifo_empty && rx_push;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    wr_en   = rx_push && !bypass && (!fifo_full || pop_mem);

    if (rx_push && !bypass && fifo_full && !pop_mem) begin
      overflow_d = 1'b1;
    end
    if (wr_en) begin
      mem_d[wr_ptr_q[RX_AW-1:0]] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_mem) begin
      rd_byte_d = mem_q[rd_ptr_q[RX_AW-1:0]];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      rd_byte_d = rx_shift_q;
    end

    rdone_d   = pop_mem || bypass;
    rd_pend_d = want_rd && !rdone_d;

    // rdone has priority; a clashing wdone slips by exactly one cycle.
    wreq          = tx_load || wdone_defer_q;
    wdone_d       = wreq && !rdone_d;
    wdone_defer_d = wreq && rdone_d;
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= 3'd0;
      tx_shift_q    <= 8'h00;
      txd_q         <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_byte_q   <= 8'h00;
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_shift_q    <= 8'h00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_pend_q     <= 1'b0;
      rdone_q       <= 1'b0;
      rd_byte_q     <= 8'h00;
      wdone_q       <= 1'b0;
      wdone_defer_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      txd_q         <= txd_d;
      pend_valid_q  <= pend_valid_d;
      pend_byte_q   <= pend_byte_d;
      rx_sync1_q    <= rxd;
      rx_sync2_q    <= rx_sync1_q;
      rx_prev_q     <= rx_sync2_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_pend_q     <= rd_pend_d;
      rdone_q       <= rdone_d;
      rd_byte_q     <= rd_byte_d;
      wdone_q       <= wdone_d;
      wdone_defer_q <= wdone_defer_d;
      overflow_q    <= overflow_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // FIFO storage, contents need no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign txd          = txd_q;
  assign uart_wdone   = wdone_q;
  assign uart_rdone   = rdone_q;
  assign uart_rd      = {24'h0, rd_byte_q};
  assign rx_overflow  = overflow_q;
  assign rx_frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_io_ctrl
//  Purpose  : Self-checking bench for uart_io_ctrl with random bytes and a
//             queue-based model of the receive FIFO and serial framing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_io_ctrl;
  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int MAXC  = 12000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_wenable = 1'b0;
  logic [31:0] uart_wd = 32'h0;
  logic        uart_wdone;
  logic        uart_renable = 1'b0;
  logic        uart_rdone;
  logic [31:0] uart_rd;
  logic        rxd = 1'b1;
  logic        txd;
  logic        rx_overflow;
  logic        rx_frame_err;

  uart_io_ctrl #(.CLK_PER_BIT(CPB), .RX_AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .uart_wenable(uart_wenable), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
    .uart_renable(uart_renable), .uart_rdone(uart_rdone), .uart_rd(uart_rd),
    .rxd(rxd), .txd(txd), .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle history of outputs, sampled mid-cycle.
  logic        txd_h [MAXC];
  logic        wd_h  [MAXC];
  logic        rd_h  [MAXC];
  logic [31:0] rdv_h [MAXC];
  int          n_coll = 0;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      txd_h[cyc] = txd;
      wd_h[cyc]  = uart_wdone;
      rd_h[cyc]  = uart_rdone;
      rdv_h[cyc] = uart_rd;
    end
    if (uart_wdone && uart_rdone) n_coll++;
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: receive queue and sticky flags.
  logic [7:0] mq[$];
  logic       ovf_m = 1'b0;
  logic       ferr_m = 1'b0;

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] wd, output int t);
    uart_wenable = 1'b1;
    uart_wd      = wd;
    t            = cyc;
    tick();
    uart_wenable = 1'b0;
  endtask

  task automatic do_read(output int t);
    uart_renable = 1'b1;
    t            = cyc;
    tick();
    uart_renable = 1'b0;
  endtask

  // One 8N1 frame on rxd; stop bit value selectable.
  task automatic send_rx(input logic [7:0] b, input logic sb, output int t0);
    t0  = cyc;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = sb;
    repeat (CPB) tick();
    rxd = 1'b1;
  endtask

  function automatic int first_rd(input int from, input int to);
    for (int i = from; i <= to && i < MAXC; i++) if (rd_h[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int first_wd(input int from, input int to);
    for (int i = from; i <= to && i < MAXC; i++) if (wd_h[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_rd(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to && i < MAXC; i++) if (rd_h[i] === 1'b1) n++;
    return n;
  endfunction

  // Expected line: start 0, eight data bits LSB first, stop 1; CPB cycles each.
  task automatic chk_frame(input string tag, input int s, input logic [7:0] b);
    logic [63:0] o = '0;
    logic [63:0] e = '0;
    for (int k = 0; k < 10 * CPB; k++) begin
      int bi = k / CPB;
      o[k] = txd_h[s + k];
      e[k] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi - 1];
    end
    chk(tag, o, e);
  endtask

  // Read from a non-empty FIFO: answer is due the very next cycle.
  task automatic read_expect(input string tag);
    int t;
    logic [7:0] e;
    do_read(t);
    tick();
    tick();
    e = mq.pop_front();
    chk({tag, "_rdone"}, rd_h[t + 1], 1);
    chk({tag, "_rd"}, rdv_h[t + 1], {24'h0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t, t1, t2, n, r, d, tw;
    logic [7:0] b, b1, b2;
    logic [31:0] rnd;

    // Reset state
    repeat (3) tick();
    chk("rst_txd", txd, 1);
    chk("rst_wdone", uart_wdone, 0);
    chk("rst_rdone", uart_rdone, 0);
    chk("rst_rd", uart_rd, 0);
    chk("rst_flags", {rx_overflow, rx_frame_err}, 0);
    rstn = 1'b1;
    repeat (2) tick();

    // Single write from idle
    do_write(32'h1234_56A5, t);
    repeat (45) tick();
    chk("tx1_wdone", wd_h[t + 1], 1);
    chk_frame("tx1_frame", t + 1, 8'hA5);
    chk("tx1_idle", txd_h[t + 1 + 10 * CPB], 1);

    // Back-to-back writes: second one waits in the pending slot
    for (int it = 0; it < 3; it++) begin
      b1 = (it == 0) ? 8'h41 : 8'($urandom);
      b2 = (it == 0) ? 8'h42 : 8'($urandom);
      rnd = $urandom;
      do_write({rnd[31:8], b1}, t1);
      repeat (2 + $urandom_range(0, 20)) tick();
      rnd = $urandom;
      do_write({rnd[31:8], b2}, t2);
      repeat (90) tick();
      chk("b2b_wdone1", wd_h[t1 + 1], 1);
      chk("b2b_wdone2", first_wd(t2 + 1, t2 + 90), t1 + 1 + 10 * CPB);
      chk_frame("b2b_frame1", t1 + 1, b1);
      chk_frame("b2b_frame2", t1 + 1 + 10 * CPB, b2);
      chk("b2b_idle", txd_h[t1 + 1 + 20 * CPB], 1);
    end

    // Receive then read from a non-empty FIFO
    for (int it = 0; it < 4; it++) begin
      b = (it == 0) ? 8'h3C : 8'($urandom);
      send_rx(b, 1'b1, n);
      model_push(b);
      repeat (3 * CPB) tick();
      read_expect("rx_read");
    end

    // Read on empty FIFO waits for the next byte
    do_read(t);
    repeat (10) tick();
    chk("pend_nordone", count_rd(t + 1, t + 10), 0);
    send_rx(8'h7E, 1'b1, n);
    repeat (8) tick();
    r = first_rd(n, n + 48);
    chk("pend_window", (r > n + 9 * CPB) && (r <= n + 10 * CPB + 3), 1);
    chk("pend_rd", (r >= 0) ? rdv_h[r] : 32'hFFFF_FFFF, 32'h0000_007E);
    d = (r > n) ? r - n : 41;

    // Overflow: five pushes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("ovf_pre", rx_overflow, 0);
      send_rx(8'(i), 1'b1, n);
      model_push(8'(i));
      repeat (3 * CPB) tick();
    end
    chk("ovf_flag", rx_overflow, ovf_m);
    for (int i = 0; i < DEPTH; i++) read_expect("ovf_read");
    do_read(t);
    repeat (20) tick();
    chk("ovf_5th_waits", count_rd(t + 1, t + 20), 0);

    // Pending read served by a byte whose rdone clashes with a write's wdone
    b  = 8'($urandom);
    b1 = 8'($urandom);
    fork
      send_rx(b, 1'b1, n);
      begin
        repeat (d - 1) tick();
        do_write({24'h0, b1}, tw);
      end
    join
    repeat (60) tick();
    chk("coll_rdone", rd_h[tw + 1], 1);
    chk("coll_rd", rdv_h[tw + 1], {24'h0, b});
    chk("coll_wdone_held", wd_h[tw + 1], 0);
    chk("coll_wdone_next", wd_h[tw + 2], 1);
    chk_frame("coll_frame", tw + 1, b1);

    // Bad stop bit, then a one-cycle glitch: neither pushes a byte
    chk("ferr_pre", rx_frame_err, 0);
    send_rx(8'($urandom), 1'b0, n);
    ferr_m = 1'b1;
    repeat (3 * CPB) tick();
    chk("ferr_flag", rx_frame_err, ferr_m);
    do_read(t);
    repeat (20) tick();
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (30) tick();
    chk("ferr_glitch_nopush", count_rd(t + 1, cyc - 1), 0);
    chk("glitch_noflag_ovf", rx_overflow, ovf_m);
    b = 8'($urandom);
    send_rx(b, 1'b1, n);
    repeat (8) tick();
    r = first_rd(n, n + 48);
    chk("ferr_after_rd", (r >= 0) ? rdv_h[r] : 32'hFFFF_FFFF, {24'h0, b});

    // Random mix of receives and reads
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic sb;
        b  = 8'($urandom);
        sb = ($urandom_range(0, 7) != 0);
        send_rx(b, sb, n);
        if (sb) model_push(b);
        else ferr_m = 1'b1;
        repeat (3 * CPB) tick();
      end else if (mq.size() > 0) begin
        read_expect("mix_read");
      end
    end
    while (mq.size() > 0) read_expect("mix_drain");
    chk("mix_flags", {rx_overflow, rx_frame_err}, {ovf_m, ferr_m});

    // Reset in the middle of a frame
    do_write(32'h0000_0000, t);
    repeat (10) tick();
    chk("mid_txd_low", txd, 0);
    rstn = 1'b0;
    tick();
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_flags", {rx_overflow, rx_frame_err}, 0);
    chk("mid_rst_rd", uart_rd, 0);
    rstn = 1'b1;
    t = cyc;
    repeat (50) tick();
    begin
      int zeros = 0;
      int wds = 0;
      for (int i = t; i < t + 48; i++) begin
        if (txd_h[i] !== 1'b1) zeros++;
        if (wd_h[i] === 1'b1) wds++;
      end
      chk("mid_rst_line_idle", zeros, 0);
      chk("mid_rst_no_wdone", wds, 0);
    end

    chk("no_collision", n_coll, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
